rptr_empty_fwft: RTL and testbench
==================================

Name: rptr_empty_fwft

Overview:
Read-side pointer and empty-flag block for the async FIFO. It is the counterpart of the write-pointer/full logic on the other clock domain. It consumes the write pointer (Gray, already two-flop synchronized into rclk), drives the Gray read pointer back to the write domain, and addresses the synchronous-read dual-port memory. A 2-entry prefetch buffer presents first-word-fall-through data to the consumer, along with empty, almost-empty, level and sticky-underflow status.

Parameters:
ADDRSIZE, 5, memory address width; depth = 2**ADDRSIZE; must be >= 2
DSIZE, 8, data word width
AEMPTY_THRESH, 4, raempty asserts when rlevel <= this value

Ports:
rclk  in  1  read-domain clock
rrst_n  in  1  reset; asynchronous assert, active-low
rinc  in  1  consumer pop; accepted only when rempty=0
rq2_wptr  in  ADDRSIZE+1  write Gray pointer, synchronized into rclk
rdata_mem  in  DSIZE  memory read data; valid one rclk after rden
rden  out  1  memory read enable (combinational)
raddr  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
rptr  out  ADDRSIZE+1  registered Gray read pointer to the write-side synchronizer
rdata  out  DSIZE  head-of-FIFO data; valid while rempty=0
rempty  out  1  no word presented to the consumer
raempty  out  1  almost empty
rlevel  out  ADDRSIZE+1  words held: memory plus prefetch buffer
runderflow  out  1  sticky: rinc seen while rempty=1

Behaviour:
- Reset values (async, rrst_n=0):
  - rbin=0, rptr=0, raddr=0.
  - mem_empty=1, so rden=0.
  - lc=0, rempty=1, raempty=1, rlevel=0.
  - rdata=0, runderflow=0, prefetch buffer invalid.
- Memory-side pointer:
  - rbinnext = rbin + rden; rgraynext = (rbinnext>>1)^rbinnext.
  - Both registered; rptr advances when a word is fetched, which frees that slot to the writer.
  - mem_empty <= (rgraynext == rq2_wptr).
- Local count lc (0..2) = outstanding fetches + valid buffer entries.
  - pop = rinc & ~rempty.
  - rden = ~mem_empty & (lc<2 | pop).
  - lc_next = lc + rden - pop.
- Prefetch buffer: head and skid registers plus one pend flag.
  - Data returned from a fetch goes to head if head is empty or being popped in that cycle, otherwise to skid.
  - On pop: head <= skid if skid valid, else the returning data if pend, else head becomes invalid.
  - rempty = ~head_valid (registered). rdata = head data; hold the last value when empty.
- Latency: rq2_wptr change to rempty falling is 3 rclk edges (mem_empty, fetch, head load).
- Throughput: with continuous rinc and a non-empty memory, one pop per cycle with no bubbles.
- Wrap-around: raddr wraps 2**ADDRSIZE-1 -> 0; the MSB of rbin/rptr toggles on each lap.
- Level:
  - wbin_s = gray2bin(rq2_wptr).
  - rlevel <= (wbin_s - rbinnext) + lc_next, modulo 2**(ADDRSIZE+1).
  - raempty <= (level_next <= AEMPTY_THRESH).
- Underflow: rinc with rempty=1 is ignored (no state change except the flag); runderflow <= 1 until reset.
- Simultaneous fetch, data return and pop in one cycle is legal; lc, skid and head must stay consistent.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight memory data is discarded, and the buffer is invalid after release.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized on ADDRSIZE.
  - Default ADDRSIZE/DSIZE constants, shared with the write side.
- One sub-module: fwft_outbuf. It contains the head/skid/pend registers and lc, and exposes pop, fetch, rdata_mem, head_valid, lc and rdata. The pointer and flag logic stays in the top module.

Test Plan:
- Reset with rq2_wptr=0 -> rptr=0, raddr=0, rden=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
- Single word (ADDRSIZE=5, DSIZE=8):
  - Stimulus: rq2_wptr 0 -> 6'b000001; memory word 0 = 8'hA5.
  - Required: rden=1 with raddr=0 one edge later; rempty=0 and rdata=8'hA5 on the 3rd edge; rptr=6'b000001.
  - Then one rinc -> rempty=1 next edge.
- Full stream:
  - Stimulus: rq2_wptr=6'b110000 (32 words, data 0..31), rinc held high.
  - Required: rdata sequence 0..31 with no bubbles; rempty=1 after the 32nd pop; rptr=6'b110000; raddr back to 0.
  - A second lap toggles the rptr MSB.
- Level and almost-empty:
  - Load 6 words, no pops -> rlevel=6, raempty=0.
  - Pop 2 -> rlevel=4, raempty=1 (AEMPTY_THRESH=4).
- Underflow: rinc=1 while rempty=1 -> runderflow=1 and stays 1; rptr and rlevel unchanged.
- Reset mid-stream:
  - Stimulus: assert rrst_n=0 during a 10-word stream with pend=1.
  - Required: all outputs at reset values within the same cycle; after release with rq2_wptr=0, rempty stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default widths.
// Used by both the read-side and write-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 5;
  localparam int FIFO_DSIZE    = 8;

  // Callers size-cast the result down to ADDRSIZE+1 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_outbuf.sv
// Two-entry prefetch buffer (head + skid) for first-word-fall-through reads.
// lc counts outstanding fetches plus valid buffer entries.
module fwft_outbuf
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  input  logic             fetch,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic             head_valid,
  output logic [1:0]       lc,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             hv_q, hv_d;
  logic             sv_q, sv_d;
  logic             pend_q;
  logic [1:0]       lc_q, lc_d;

  always_comb begin
    head_d = head_q;
    hv_d   = hv_q;
    skid_d = skid_q;
    sv_d   = sv_q;
    if (pop) begin
      if (sv_q) begin
        head_d = skid_q;
        sv_d   = 1'b0;
      end else if (pend_q) begin
        head_d = rdata_mem;
      end else begin
        hv_d = 1'b0;
      end
      if (sv_q && pend_q) begin
        skid_d = rdata_mem;
        sv_d   = 1'b1;
      end
    end else if (pend_q) begin
      if (!hv_q) begin
        head_d = rdata_mem;
        hv_d   = 1'b1;
      end else begin
        skid_d = rdata_mem;
        sv_d   = 1'b1;
      end
    end
  end

  assign lc_d = lc_q + {1'b0, fetch} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      hv_q   <= 1'b0;
      sv_q   <= 1'b0;
      pend_q <= 1'b0;
      lc_q   <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      hv_q   <= hv_d;
      sv_q   <= sv_d;
      pend_q <= fetch;
      lc_q   <= lc_d;
    end
  end

  assign head_valid = hv_q;
  assign lc         = lc_q;
  assign rdata      = head_q;

endmodule

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read side: Gray read pointer, memory fetch control,
// FWFT output buffer and empty / almost-empty / level / underflow status.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int DSIZE         = FIFO_DSIZE,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0]    rdata_mem,
  output logic                rden,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [DSIZE-1:0]    rdata,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_T = PW'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              mem_empty_q, mem_empty_d;
  logic              raempty_q, raempty_d;
  logic              runderflow_q, runderflow_d;
  logic              head_valid;
  logic              pop;
  logic [1:0]        lc, lc_next;

  assign rempty  = ~head_valid;
  assign pop     = rinc & ~rempty;
  assign rden    = ~mem_empty_q & ((lc < 2'd2) | pop);
  assign lc_next = lc + {1'b0, rden} - {1'b0, pop};

  assign rbin_d      = rbin_q + {{ADDRSIZE{1'b0}}, rden};
  assign rptr_d      = PW'(bin2gray(32'(rbin_d)));
  assign mem_empty_d = (rptr_d == rq2_wptr);

  // Level counts words still in memory plus those already fetched.
  assign wbin_s       = PW'(gray2bin(32'(rq2_wptr)));
  assign rlevel_d     = (wbin_s - rbin_d)
                      + {{(ADDRSIZE-1){1'b0}}, lc_next};
  assign raempty_d    = (rlevel_d <= AE_T);
  assign runderflow_d = runderflow_q | (rinc & rempty);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      mem_empty_q  <= 1'b1;
      rlevel_q     <= '0;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      mem_empty_q  <= mem_empty_d;
      rlevel_q     <= rlevel_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  fwft_outbuf #(
    .DSIZE(DSIZE)
  ) u_outbuf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .pop       (pop),
    .fetch     (rden),
    .rdata_mem (rdata_mem),
    .head_valid(head_valid),
    .lc        (lc),
    .rdata     (rdata)
  );

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rlevel     = rlevel_q;
  assign raempty    = raempty_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: memory model plus data scoreboard.
// Words are queued when written and checked on each accepted pop.
module tb_rptr_empty_fwft;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [5:0] rq2_wptr;
  logic [7:0] rdata_mem;
  logic       rden;
  logic [4:0] raddr;
  logic [5:0] rptr;
  logic [7:0] rdata;
  logic       rempty;
  logic       raempty;
  logic [5:0] rlevel;
  logic       runderflow;

  logic [7:0] mem [32];
  logic [7:0] sb [$];
  logic [5:0] wbin;
  int tests = 0;
  int fails = 0;

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rden) rdata_mem <= mem[raddr];
  end

  rptr_empty_fwft dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rinc      (rinc),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .rden      (rden),
    .raddr     (raddr),
    .rptr      (rptr),
    .rdata     (rdata),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel),
    .runderflow(runderflow)
  );

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic write_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      mem[wbin[4:0]] = 8'(start + i);
      sb.push_back(8'(start + i));
      wbin = wbin + 6'd1;
    end
    rq2_wptr = to_gray(wbin);
  endtask

  // Called at a negedge; checks head data when a pop will be accepted.
  task automatic cycle(input logic inc);
    logic [7:0] exp;
    rinc = inc;
    if (inc && !rempty) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pop_extra got=%h exp=none", rdata);
      end else begin
        exp = sb.pop_front();
        if (rdata !== exp) begin
          fails++;
          $display("FAIL pop_data got=%h exp=%h", rdata, exp);
        end
      end
    end
    @(negedge rclk);
  endtask

  task automatic wait_nonempty(input string name);
    int k = 0;
    while (rempty && k < 10) begin
      @(negedge rclk);
      k++;
    end
    tests++;
    if (rempty) begin
      fails++;
      $display("FAIL %s_timeout rempty=%b exp=0", name, rempty);
    end
  endtask

  task automatic do_reset();
    rinc     = 1'b0;
    rq2_wptr = '0;
    rrst_n   = 1'b0;
    wbin     = '0;
    sb.delete();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if (rptr !== 6'd0 || raddr !== 5'd0 || rden !== 1'b0 ||
        rempty !== 1'b1 || raempty !== 1'b1 || rlevel !== 6'd0 ||
        runderflow !== 1'b0 || rdata !== 8'h00) begin
      fails++;
      $display("FAIL %s got rptr=%h raddr=%h rden=%b re=%b rae=%b lvl=%0d uf=%b d=%h exp=0/0/0/1/1/0/0/00",
               name, rptr, raddr, rden, rempty, raempty, rlevel,
               runderflow, rdata);
    end
  endtask

  task automatic test_reset();
    rinc     = 1'b0;
    rq2_wptr = '0;
    rrst_n   = 1'b0;
    wbin     = '0;
    @(negedge rclk);
    @(negedge rclk);
    check_reset_vals("reset");
    rrst_n = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    check_reset_vals("reset_idle");
  endtask

  task automatic test_single();
    do_reset();
    write_words(1, 8'hA5 - 0);
    mem[0] = 8'hA5;
    sb.delete();
    sb.push_back(8'hA5);
    @(negedge rclk);
    tests++;
    if (rden !== 1'b1 || raddr !== 5'd0) begin
      fails++;
      $display("FAIL single_fetch rden=%b raddr=%0d exp=1/0", rden, raddr);
    end
    @(negedge rclk);
    tests++;
    if (rptr !== 6'b000001 || rempty !== 1'b1) begin
      fails++;
      $display("FAIL single_edge2 rptr=%b re=%b exp=000001/1", rptr, rempty);
    end
    @(negedge rclk);
    tests++;
    if (rempty !== 1'b0 || rdata !== 8'hA5) begin
      fails++;
      $display("FAIL single_edge3 re=%b d=%h exp=0/a5", rempty, rdata);
    end
    cycle(1'b1);
    rinc = 1'b0;
    tests++;
    if (rempty !== 1'b1 || rlevel !== 6'd0) begin
      fails++;
      $display("FAIL single_pop re=%b lvl=%0d exp=1/0", rempty, rlevel);
    end
  endtask

  task automatic stream_lap(input string name, input logic [5:0] exp_ptr);
    wait_nonempty(name);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (rempty) begin
        fails++;
        $display("FAIL %s_bubble idx=%0d re=%b exp=0", name, i, rempty);
      end
      cycle(1'b1);
    end
    rinc = 1'b0;
    tests++;
    if (rempty !== 1'b1 || rptr !== exp_ptr || raddr !== 5'd0 ||
        sb.size() != 0) begin
      fails++;
      $display("FAIL %s_end re=%b rptr=%b raddr=%0d left=%0d exp=1/%b/0/0",
               name, rempty, rptr, raddr, sb.size(), exp_ptr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    write_words(32, 0);
    stream_lap("lap1", 6'b110000);
    write_words(32, 32);
    stream_lap("lap2", 6'b000000);
  endtask

  task automatic test_level();
    do_reset();
    write_words(6, 8'h40);
    repeat (6) @(negedge rclk);
    tests++;
    if (rlevel !== 6'd6 || raempty !== 1'b0) begin
      fails++;
      $display("FAIL level6 lvl=%0d ae=%b exp=6/0", rlevel, raempty);
    end
    cycle(1'b1);
    cycle(1'b1);
    rinc = 1'b0;
    tests++;
    if (rlevel !== 6'd4 || raempty !== 1'b1) begin
      fails++;
      $display("FAIL level4 lvl=%0d ae=%b exp=4/1", rlevel, raempty);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1);
    rinc = 1'b0;
    tests++;
    if (rlevel !== 6'd0 || rempty !== 1'b1 || sb.size() != 0) begin
      fails++;
      $display("FAIL level_drain lvl=%0d re=%b left=%0d exp=0/1/0",
               rlevel, rempty, sb.size());
    end
  endtask

  task automatic test_underflow();
    logic [5:0] p0, l0;
    p0 = rptr;
    l0 = rlevel;
    rinc = 1'b1;
    @(negedge rclk);
    rinc = 1'b0;
    tests++;
    if (runderflow !== 1'b1 || rptr !== p0 || rlevel !== l0) begin
      fails++;
      $display("FAIL underflow uf=%b rptr=%b lvl=%0d exp=1/%b/%0d",
               runderflow, rptr, rlevel, p0, l0);
    end
    repeat (3) @(negedge rclk);
    tests++;
    if (runderflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky uf=%b exp=1", runderflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_words(10, 8'h80);
    wait_nonempty("mid");
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    #2 rrst_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    rinc     = 1'b0;
    rq2_wptr = '0;
    wbin     = '0;
    sb.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (5) @(negedge rclk);
    tests++;
    if (rempty !== 1'b1 || rlevel !== 6'd0 || rden !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after re=%b lvl=%0d rden=%b exp=1/0/0",
               rempty, rlevel, rden);
    end
  endtask

  initial begin
    rinc     = 1'b0;
    rq2_wptr = '0;
    rrst_n   = 1'b0;
    wbin     = '0;
    test_reset();
    test_single();
    test_stream();
    test_level();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
